// File: rtl/float64_recode_arbiter.sv
// float64_recode_arbiter
//   Shares a single float64 -> recoded float65 converter among NUM_REQ
//   requesters (for example FP load writeback ports). A round-robin arbiter
//   picks one requester per cycle. Its operand is converted combinationally
//   and captured in one result register, so a result appears one cycle after
//   it is accepted.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   req_valid[i]       requester i presents an operand
//   req_ready[i]       requester i accepted this cycle (one-hot or zero)
//   req_data           operand i at bits [64*i+63:64*i]
//   req_tag            tag i at bits [TAG_W*i+TAG_W-1:TAG_W*i]
//   resp_valid         result register holds a result
//   resp_ready         consumer takes the result this cycle
//   resp_data          recoded float65 {sign, exp[11:0], fract[51:0]}
//   resp_src           index of the requester that produced resp_data
//   resp_tag           tag captured with the request
//   busy               resp_valid | (|req_valid)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never waits for ready. Once valid is raised, data and
// tag stay stable until the transfer. Ready may depend on valid but never
// on data or tag.
module float64_recode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2,
  parameter int TAG_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [64*NUM_REQ-1:0]    req_data,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [64:0]              resp_data,
  output logic [SRC_W-1:0]         resp_src,
  output logic [TAG_W-1:0]         resp_tag,
  output logic                     busy
);

  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [SRC_W-1:0] rr_ptr;
  logic             can_accept;
  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W:0]   scan_idx;
  logic             xfer;

  // The result register can take a new value when it is empty or is being
  // drained in this same cycle.
  assign can_accept = ~resp_valid | resp_ready;

  // Scan upward from rr_ptr with wraparound. The first valid index wins.
  // scan_idx has one extra bit so that rr_ptr + off cannot overflow before
  // the wrap subtraction.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = {1'b0, rr_ptr} + (SRC_W+1)'(off);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!grant_any && req_valid[scan_idx[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[SRC_W-1:0];
      end
    end
  end

  assign xfer = grant_any & can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand and tag mux. This uses only the grant index, so ready never
  // depends on the data or tag inputs.
  logic [63:0]      sel_data;
  logic [TAG_W-1:0] sel_tag;

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_data = req_data[64*i +: 64];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // float64 -> recoded float65 converter
  // ---------------------------------------------------------------------
  // Counts leading zeros of a 52-bit fraction. The loop runs upward, so the
  // highest set bit is assigned last and wins. An all-zero fraction returns
  // 51, but the exponent is forced to zero in that case, so the value does
  // not matter.
  function automatic logic [5:0] clz52(input logic [51:0] f);
    logic [5:0] n;
    n = 6'd51;
    for (int i = 0; i < 52; i++) begin
      if (f[i]) begin
        n = 6'(51 - i);
      end
    end
    return n;
  endfunction

  logic        in_sign;
  logic [10:0] exp_in;
  logic [51:0] fract_in;
  logic        exp_zero;
  logic        fract_zero;
  logic        is_zero;
  logic        is_special;
  logic        is_nan;
  logic [5:0]  norm_dist;
  logic [51:0] norm_fract;
  logic [51:0] sub_fract;
  logic [11:0] adj_exp;
  logic [11:0] exp_out;
  logic [51:0] fract_out;
  logic [64:0] conv_out;

  assign in_sign    = sel_data[63];
  assign exp_in     = sel_data[62:52];
  assign fract_in   = sel_data[51:0];
  assign exp_zero   = (exp_in == 11'd0);
  assign fract_zero = (fract_in == 52'd0);
  assign is_zero    = exp_zero & fract_zero;

  // Subnormals are normalised. Shifting the leading one up to bit 52 drops
  // it, because that bit becomes the implicit bit.
  assign norm_dist  = clz52(fract_in);
  assign norm_fract = fract_in << norm_dist;
  assign sub_fract  = {norm_fract[50:0], 1'b0};

  // Normal operands are rebiased by adding 0x401. For subnormals,
  // (norm_dist ^ 0xFFF) + 0x402 wraps modulo 2^12 to 0x401 - norm_dist.
  // The smallest subnormal therefore maps to 0x3CE.
  assign adj_exp = exp_zero ? ({6'h3F, ~norm_dist} + 12'h402)
                            : ({1'b0, exp_in} + 12'h401);

  // exp_in == 0x7FF maps to 0xC00 (inf). NaN also sets bit 9.
  assign is_special = (adj_exp[11:10] == 2'b11);
  assign is_nan     = is_special & ~fract_zero;

  assign exp_out   = is_zero ? 12'd0
                             : {adj_exp[11:10], adj_exp[9] | is_nan, adj_exp[8:0]};
  assign fract_out = exp_zero ? sub_fract : fract_in;
  assign conv_out  = {in_sign, exp_out, fract_out};

  // ---------------------------------------------------------------------
  // Result register and round-robin pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_src   <= '0;
      resp_tag   <= '0;
      rr_ptr     <= '0;
    end else begin
      if (xfer) begin
        resp_valid <= 1'b1;
        resp_data  <= conv_out;
        resp_src   <= grant_idx;
        resp_tag   <= sel_tag;
        rr_ptr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign busy = resp_valid | (|req_valid);

endmodule

// File: tb/tb_float64_recode_arbiter.sv
// Testbench for float64_recode_arbiter with NUM_REQ=4, SRC_W=2, TAG_W=5.
// Directed steps and a random phase run in one initial block. A monitor
// process pushes the expected {data, src, tag} for every accepted request.
// It pops and compares when the consumer takes a result.
module tb_float64_recode_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;
  localparam int TAG_W   = 5;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [64*NUM_REQ-1:0]    req_data;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [64:0]              resp_data;
  logic [SRC_W-1:0]         resp_src;
  logic [TAG_W-1:0]         resp_tag;
  logic                     busy;

  float64_recode_arbiter #(
    .NUM_REQ(NUM_REQ),
    .SRC_W  (SRC_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_src  (resp_src),
    .resp_tag  (resp_tag),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [71:0] exp_q[$];
  int compared;
  int mismatched;
  int n_xfer;

  // Reference recoder. It works case by case on the IEEE classes and uses
  // the subnormal's MSB position directly.
  function automatic logic [64:0] ref_recode(input logic [63:0] d);
    logic [10:0] e;
    logic [51:0] f;
    logic [11:0] xe;
    logic [51:0] xf;
    int p;
    e = d[62:52];
    f = d[51:0];
    p = 0;
    if (e == 11'd0 && f == 52'd0) begin
      xe = 12'd0;
      xf = 52'd0;
    end else if (e == 11'h7FF) begin
      xe = (f == 52'd0) ? 12'hC00 : 12'hE00;
      xf = f;
    end else if (e == 11'd0) begin
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      xe = 12'h3CE + 12'(p);
      xf = 52'(f << (52 - p));
    end else begin
      xe = {1'b0, e} + 12'h401;
      xf = f;
    end
    return {d[63], xe, xf};
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: d[62:52] = 11'd0;
      1: d[62:52] = 11'h7FF;
      2: begin
        d[62:52] = 11'd0;
        d[51:0]  = 52'd1 << $urandom_range(0, 51);
      end
      3: d[51:0] = 52'd0;
      4: d[62:0] = 63'd0;
      default: ;
    endcase
    return d;
  endfunction

  task automatic check(input string name, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [63:0] d, input logic [TAG_W-1:0] t);
    req_valid[i]              = 1'b1;
    req_data[64*i +: 64]      = d;
    req_tag[TAG_W*i +: TAG_W] = t;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [71:0] got;
    logic [71:0] want;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        check("busy", busy, resp_valid | (|req_valid));
        check("ready_rule", (($onehot0(req_ready)) && ((req_ready & ~req_valid) == '0)), 1'b1);
        if (resp_valid && !resp_ready) check("stall_ready", req_ready, 0);
        if (resp_valid && resp_ready) begin
          got = {resp_data, resp_src, resp_tag};
          compared++;
          assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL resp_unexpected: observed %h expected none", got);
          end
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("resp", got, want);
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            exp_q.push_back({ref_recode(req_data[64*i +: 64]), 2'(i), req_tag[TAG_W*i +: TAG_W]});
            n_xfer++;
          end
        end
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [NUM_REQ-1:0] g;
    int start;
    int cyc;

    compared   = 0;
    mismatched = 0;
    n_xfer     = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_tag    = '0;
    resp_ready = 1'b0;

    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_src", resp_src, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rr_ptr", dut.rr_ptr, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Single request: 1.0 on port 0 with tag 5
    set_port(0, 64'h3FF0000000000000, 5'd5);
    resp_ready = 1'b1;
    #1;
    check("t1_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_data", resp_data, 65'h08000000000000000);
    check("t1_resp_src", resp_src, 0);
    check("t1_resp_tag", resp_tag, 5);

    // NaN on port 2, zero on port 3, smallest subnormal on port 3
    set_port(2, 64'h7FF8000000000000, 5'd9);
    tick();
    req_valid = '0;
    #1;
    check("t2_nan_data", resp_data, 65'h0E008000000000000);
    check("t2_nan_src", resp_src, 2);
    set_port(3, 64'h0, 5'd17);
    tick();
    req_valid = '0;
    #1;
    check("t2_zero_data", resp_data, 65'h0);
    check("t2_zero_src", resp_src, 3);
    set_port(3, 64'h0000000000000001, 5'd3);
    tick();
    req_valid = '0;
    #1;
    check("t5_subn_data", resp_data, 65'h03CE0000000000000);
    check("t5_rr_ptr", dut.rr_ptr, 0);

    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < NUM_REQ; i++) set_port(i, rand_operand(), 5'(20 + i));
    for (int c = 0; c < 8; c++) begin
      #1;
      check("t3_grant", req_ready, 4'b0001 << (c % 4));
      tick();
      req_data[64*(c%4) +: 64] = rand_operand();
    end
    req_valid = '0;
    tick();

    // Backpressure: hold a result from port 1 for 3 cycles
    resp_ready = 1'b0;
    set_port(1, 64'hC000000000000000, 5'd11);
    tick();
    req_valid[1] = 1'b0;
    set_port(0, rand_operand(), 5'd1);
    set_port(3, rand_operand(), 5'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_ready", req_ready, 0);
      check("t4_hold_valid", resp_valid, 1);
      check("t4_hold_data", resp_data, 65'h18010000000000000);
      check("t4_hold_src", resp_src, 1);
      check("t4_hold_tag", resp_tag, 11);
      check("t4_rr_ptr", dut.rr_ptr, 2);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("t4_refill_ready", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    #1;
    check("t4_refill_src", resp_src, 3);
    check("t4_next_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;

    // Reset with a held result and rr_ptr=2
    set_port(1, rand_operand(), 5'd7);
    #1;
    check("t6_pre_ready", req_ready, 4'b0010);
    tick();
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    check("t6_pre_rr_ptr", dut.rr_ptr, 2);
    check("t6_pre_valid", resp_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", resp_valid, 0);
    check("t6_rst_rr_ptr", dut.rr_ptr, 0);
    check("t6_rst_data", resp_data, 0);
    tick();
    tick();
    reset = 1'b0;
    set_port(0, rand_operand(), 5'd2);
    set_port(2, rand_operand(), 5'd6);
    resp_ready = 1'b1;
    #1;
    check("t6_first_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("t6_first_src", resp_src, 0);
    check("t6_second_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();

    // Random phase: 10k conversions with random backpressure
    start = n_xfer;
    cyc   = 0;
    while ((n_xfer - start) < 10000 && cyc < 40000) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) != 0) set_port(i, rand_operand(), 5'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~g;
      cyc++;
    end
    check("rand_count_reached", ((n_xfer - start) >= 10000), 1);

    // Drain
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    check("drain_valid", resp_valid, 0);
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
